// File: rtl/layer_engine_pkg.sv
// Shared definitions for the layer engine stages: opcode field positions,
// default opcode width and the pooler FSM state encoding.
package layer_engine_pkg;

  localparam int unsigned LE_OPCODE_WIDTH = 64;

  // Pooler opcode fields
  localparam int unsigned POOL_NUM_INPUTS_FIELD_LO = 0;
  localparam int unsigned POOL_NUM_INPUTS_FIELD_HI = 15;
  localparam int unsigned POOL_SIZE_FIELD_LO       = 16;
  localparam int unsigned POOL_SIZE_FIELD_HI       = 19;
  localparam int unsigned POOL_BYPASS_FIELD        = 20;

  // One-hot pooler states
  typedef enum logic [4:0] {
    StIdle   = 5'b00001,
    StDecode = 5'b00010,
    StBusy   = 5'b00100,
    StFlush  = 5'b01000,
    StDone   = 5'b10000
  } pool_state_e;

  // Effective words per group: bypass and a zero size both collapse to 1.
  function automatic logic [15:0] pool_eff_size(input logic [3:0] size, input logic bypass);
    if (bypass || (size == 4'd0)) begin
      return 16'd1;
    end
    return {12'd0, size};
  endfunction

endpackage

// File: rtl/layer_engine_pool_lane.sv
// Combinational signed maximum of one lane.
module layer_engine_pool_lane #(
  parameter int unsigned C_LANE_WIDTH = 16
) (
  input  logic [C_LANE_WIDTH-1:0] a_i,
  input  logic [C_LANE_WIDTH-1:0] b_i,
  output logic [C_LANE_WIDTH-1:0] max_o
);

  // Pick the larger operand under two's-complement ordering
  always_comb begin
    max_o = ($signed(a_i) > $signed(b_i)) ? a_i : b_i;
  end

endmodule

// File: rtl/layer_engine_pooler.sv
// Streaming max-pool stage: reduces each group of pool_size input words to one
// output word by lane-wise signed max, driven by the layer engine opcode handshake.
module layer_engine_pooler
  import layer_engine_pkg::*;
#(
  parameter int unsigned C_DATA_WIDTH   = 128,
  parameter int unsigned C_LANE_WIDTH   = 16,
  parameter int unsigned C_OPCODE_WIDTH = LE_OPCODE_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [C_OPCODE_WIDTH-1:0] opcode,
  input  logic                      opcode_valid,
  output logic                      opcode_accept,
  output logic                      opcode_complete,
  input  logic [C_DATA_WIDTH-1:0]   datain,
  input  logic                      datain_valid,
  output logic                      datain_ready,
  output logic [C_DATA_WIDTH-1:0]   dataout,
  output logic                      dataout_valid,
  input  logic                      dataout_ready
);

  localparam int unsigned Lanes = C_DATA_WIDTH / C_LANE_WIDTH;

  pool_state_e state_q, state_d;

  // Opcode fields captured in idle, decoded one cycle later
  logic [15:0] cap_num_q, cap_num_d;
  logic [3:0]  cap_size_q, cap_size_d;
  logic        cap_bypass_q, cap_bypass_d;

  logic [15:0] num_inputs_q, num_inputs_d;
  logic [15:0] pool_size_q, pool_size_d;
  logic [15:0] in_cnt_q, in_cnt_d;
  logic [15:0] grp_cnt_q, grp_cnt_d;

  logic [C_DATA_WIDTH-1:0] acc_q, acc_d;
  logic [C_DATA_WIDTH-1:0] dout_q, dout_d;
  logic                    dout_valid_q, dout_valid_d;

  logic [C_DATA_WIDTH-1:0] lane_max;
  logic [C_DATA_WIDTH-1:0] merged;
  logic                    in_xfer;
  logic                    out_xfer;
  logic                    last_in;
  logic                    group_close;

  // Upper opcode bits carry fields for other stages
  logic unused_opcode_bits;
  assign unused_opcode_bits = ^opcode[C_OPCODE_WIDTH-1:POOL_BYPASS_FIELD+1];

  for (genvar l = 0; l < Lanes; l++) begin : g_lane
    layer_engine_pool_lane #(
      .C_LANE_WIDTH(C_LANE_WIDTH)
    ) u_lane (
      .a_i  (acc_q[l*C_LANE_WIDTH +: C_LANE_WIDTH]),
      .b_i  (datain[l*C_LANE_WIDTH +: C_LANE_WIDTH]),
      .max_o(lane_max[l*C_LANE_WIDTH +: C_LANE_WIDTH])
    );
  end

  // Handshake decode and group bookkeeping
  always_comb begin
    datain_ready = (state_q == StBusy) && (!dout_valid_q || dataout_ready);
    in_xfer      = datain_valid && datain_ready;
    out_xfer     = dout_valid_q && dataout_ready;
    last_in      = (in_cnt_q == (num_inputs_q - 16'd1));
    group_close  = (grp_cnt_q == (pool_size_q - 16'd1)) || last_in;
    // The first word of a group replaces the accumulator outright
    merged       = (grp_cnt_q == 16'd0) ? datain : lane_max;
  end

  // Next-state logic and handshake pulses
  always_comb begin
    state_d         = state_q;
    cap_num_d       = cap_num_q;
    cap_size_d      = cap_size_q;
    cap_bypass_d    = cap_bypass_q;
    num_inputs_d    = num_inputs_q;
    pool_size_d     = pool_size_q;
    in_cnt_d        = in_cnt_q;
    grp_cnt_d       = grp_cnt_q;
    acc_d           = acc_q;
    dout_d          = dout_q;
    dout_valid_d    = dout_valid_q;
    opcode_accept   = 1'b0;
    opcode_complete = 1'b0;

    // A closing word below may re-set valid in the same cycle (no bubble)
    if (out_xfer) begin
      dout_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (opcode_valid) begin
          cap_num_d    = opcode[POOL_NUM_INPUTS_FIELD_HI:POOL_NUM_INPUTS_FIELD_LO];
          cap_size_d   = opcode[POOL_SIZE_FIELD_HI:POOL_SIZE_FIELD_LO];
          cap_bypass_d = opcode[POOL_BYPASS_FIELD];
          state_d      = StDecode;
        end
      end
      StDecode: begin
        opcode_accept = 1'b1;
        num_inputs_d  = cap_num_q;
        pool_size_d   = pool_eff_size(cap_size_q, cap_bypass_q);
        in_cnt_d      = 16'd0;
        grp_cnt_d     = 16'd0;
        state_d       = (cap_num_q == 16'd0) ? StDone : StBusy;
      end
      StBusy: begin
        if (in_xfer) begin
          in_cnt_d = in_cnt_q + 16'd1;
          if (group_close) begin
            dout_d       = merged;
            dout_valid_d = 1'b1;
            grp_cnt_d    = 16'd0;
          end else begin
            acc_d     = merged;
            grp_cnt_d = grp_cnt_q + 16'd1;
          end
          if (last_in) begin
            state_d = StFlush;
          end
        end
      end
      StFlush: begin
        if (out_xfer) begin
          state_d = StDone;
        end
      end
      StDone: begin
        opcode_complete = 1'b1;
        state_d         = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, counters, accumulator and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cap_num_q    <= '0;
      cap_size_q   <= '0;
      cap_bypass_q <= 1'b0;
      num_inputs_q <= '0;
      pool_size_q  <= '0;
      in_cnt_q     <= '0;
      grp_cnt_q    <= '0;
      acc_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cap_num_q    <= cap_num_d;
      cap_size_q   <= cap_size_d;
      cap_bypass_q <= cap_bypass_d;
      num_inputs_q <= num_inputs_d;
      pool_size_q  <= pool_size_d;
      in_cnt_q     <= in_cnt_d;
      grp_cnt_q    <= grp_cnt_d;
      acc_q        <= acc_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dataout       = dout_q;
  assign dataout_valid = dout_valid_q;

endmodule

// File: tb/tb_layer_engine_pooler.sv
// Scoreboard bench for layer_engine_pooler: jobs push expected pooled words,
// a negedge monitor pops and compares them and checks handshake timing.
module tb_layer_engine_pooler;

  localparam int DW = 128;
  localparam int LW = 16;
  localparam int OW = 64;
  localparam int LANES = DW / LW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [OW-1:0] opcode = '0;
  logic          opcode_valid = 1'b0;
  logic          opcode_accept;
  logic          opcode_complete;
  logic [DW-1:0] datain = '0;
  logic          datain_valid = 1'b0;
  logic          datain_ready;
  logic [DW-1:0] dataout;
  logic          dataout_valid;
  logic          dataout_ready = 1'b1;

  layer_engine_pooler #(
    .C_DATA_WIDTH  (DW),
    .C_LANE_WIDTH  (LW),
    .C_OPCODE_WIDTH(OW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .opcode         (opcode),
    .opcode_valid   (opcode_valid),
    .opcode_accept  (opcode_accept),
    .opcode_complete(opcode_complete),
    .datain         (datain),
    .datain_valid   (datain_valid),
    .datain_ready   (datain_ready),
    .dataout        (dataout),
    .dataout_valid  (dataout_valid),
    .dataout_ready  (dataout_ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  logic [DW-1:0] stim_q[$];
  int  accept_cyc = 0;
  int  first_xfer_cyc = 0;
  int  last_xfer_cyc = 0;
  int  out_cnt = 0;
  int  complete_cnt = 0;
  bit  job_zero = 0;
  int  hold_cnt = 0;
  int  ready_pct = 100;

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Consumer: random back-pressure plus an optional forced stall window
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (hold_cnt > 0) begin
        dataout_ready = 1'b0;
        hold_cnt--;
      end else begin
        dataout_ready = ($urandom_range(99) < ready_pct);
      end
    end
  end

  // Monitor: scoreboard pops, stability under stall, completion timing
  initial begin
    bit            prev_hold;
    logic [DW-1:0] prev_data;
    prev_hold = 0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (prev_hold) begin
          check("hold_valid", DW'(dataout_valid), DW'(1));
          check("hold_data", dataout, prev_data);
        end
        if (dataout_valid && !dataout_ready) begin
          check("stall_datain_ready", DW'(datain_ready), DW'(0));
        end
        if (dataout_valid && dataout_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got %h expected none", dataout);
          end else begin
            check("dataout", dataout, exp_q.pop_front());
          end
          got_q.push_back(dataout);
          if (out_cnt == 0) first_xfer_cyc = cyc;
          last_xfer_cyc = cyc;
          out_cnt++;
        end
        if (opcode_accept) accept_cyc = cyc;
        if (opcode_complete) begin
          complete_cnt++;
          check("complete_timing", DW'(cyc), DW'(job_zero ? accept_cyc + 1 : last_xfer_cyc + 1));
        end
        prev_hold = dataout_valid && !dataout_ready;
        prev_data = dataout;
      end else begin
        prev_hold = 0;
      end
    end
  end

  // Issue one job; the reference model pools the words with plain signed arithmetic
  task automatic run_job(input int num, input int sz, input bit byp, input int vpct,
                         input int hold_at, input bit use_stim);
    logic [DW-1:0] words[$];
    logic [DW-1:0] r;
    logic [OW-1:0] op;
    shortint       best;
    shortint       v;
    int            eff;
    int            t;
    int            idx;
    int            c0;
    int            drive_cyc;
    bit            held;
    words = {};
    for (int i = 0; i < num; i++) begin
      if (use_stim) words.push_back(stim_q[i]);
      else words.push_back({$urandom, $urandom, $urandom, $urandom});
    end
    eff = (byp || sz == 0) ? 1 : sz;
    for (int g = 0; g < num; g += eff) begin
      for (int l = 0; l < LANES; l++) begin
        best = words[g][l*LW +: LW];
        for (int k = g + 1; k < g + eff && k < num; k++) begin
          v = words[k][l*LW +: LW];
          if (v > best) best = v;
        end
        r[l*LW +: LW] = best;
      end
      exp_q.push_back(r);
    end
    out_cnt  = 0;
    got_q    = {};
    c0       = complete_cnt;
    job_zero = (num == 0);
    op = {$urandom, $urandom};
    op[15:0]  = num[15:0];
    op[19:16] = sz[3:0];
    op[20]    = byp;

    @(posedge clk);
    #1;
    opcode = op;
    opcode_valid = 1'b1;
    drive_cyc = cyc;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!opcode_accept && t < 50);
    check("accept_latency", DW'(cyc), DW'(drive_cyc + 1));
    @(posedge clk);
    #1;
    opcode_valid = 1'b0;
    opcode = {$urandom, $urandom};

    idx = 0;
    t = 0;
    held = 0;
    while (idx < num && t < 5000) begin
      if (!held && idx == hold_at) begin
        hold_cnt = 10;
        held = 1;
      end
      datain = words[idx];
      datain_valid = ($urandom_range(99) < vpct);
      @(negedge clk);
      if (datain_valid && datain_ready) idx++;
      @(posedge clk);
      #1;
      t++;
    end
    datain_valid = 1'b0;
    if (idx < num) begin
      checks++;
      errors++;
      $display("FAIL input_timeout: got %0d words expected %0d", idx, num);
    end

    t = 0;
    while (complete_cnt == c0 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    repeat (2) @(posedge clk);
    check("complete_once", DW'(complete_cnt - c0), DW'(1));
    check("out_count", DW'(out_cnt), DW'((num + eff - 1) / eff));
    check("scoreboard_drained", DW'(exp_q.size()), DW'(0));
  endtask

  initial begin
    logic [DW-1:0] w;
    int c0;

    // Reset state
    @(negedge clk);
    check("rst_accept", DW'(opcode_accept), DW'(0));
    check("rst_complete", DW'(opcode_complete), DW'(0));
    check("rst_datain_ready", DW'(datain_ready), DW'(0));
    check("rst_dataout_valid", DW'(dataout_valid), DW'(0));
    check("rst_dataout", dataout, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // lane0: 3, -5, 7, 2 with pool size 2
    stim_q = {};
    for (int i = 0; i < 4; i++) stim_q.push_back({$urandom, $urandom, $urandom, $urandom});
    stim_q[0][15:0] = 16'd3;
    stim_q[1][15:0] = 16'hFFFB;
    stim_q[2][15:0] = 16'd7;
    stim_q[3][15:0] = 16'd2;
    run_job(4, 2, 0, 100, -1, 1);
    if (got_q.size() >= 2) begin
      check("lane0_out0", DW'(got_q[0][15:0]), DW'(16'd3));
      check("lane0_out1", DW'(got_q[1][15:0]), DW'(16'd7));
    end else begin
      checks++;
      errors++;
      $display("FAIL lane0_outputs: got %0d outputs expected 2", got_q.size());
    end

    // Partial last group passes word 5 through unchanged
    stim_q = {};
    for (int i = 0; i < 5; i++) stim_q.push_back({$urandom, $urandom, $urandom, $urandom});
    run_job(5, 2, 0, 100, -1, 1);
    if (got_q.size() == 3) check("partial_group", got_q[2], stim_q[4]);
    else begin
      checks++;
      errors++;
      $display("FAIL partial_outputs: got %0d outputs expected 3", got_q.size());
    end

    // Signed lane ordering
    stim_q = {};
    w = '0;
    w[31:0] = {16'h8000, 16'h7FFF};
    stim_q.push_back(w);
    w[31:0] = {16'hFFFF, 16'h0001};
    stim_q.push_back(w);
    run_job(2, 2, 0, 100, -1, 1);
    if (got_q.size() == 1) check("sign_lanes", got_q[0], DW'(32'hFFFF7FFF));
    else begin
      checks++;
      errors++;
      $display("FAIL sign_outputs: got %0d outputs expected 1", got_q.size());
    end

    // Pool size 1 at full rate
    run_job(16, 1, 0, 100, -1, 0);
    check("full_rate_span", DW'(last_xfer_cyc - first_xfer_cyc), DW'(15));

    // Ten-cycle consumer stall mid-job
    run_job(12, 3, 0, 100, 4, 0);

    // Empty job, bypass and zero size field
    run_job(0, 2, 0, 100, -1, 0);
    run_job(6, 3, 1, 100, -1, 0);
    run_job(5, 0, 0, 100, -1, 0);

    // Random jobs with random valid/ready gaps
    ready_pct = 70;
    for (int j = 0; j < 6; j++) begin
      run_job($urandom_range(1, 14), $urandom_range(0, 15), $urandom_range(0, 1), 70, -1, 0);
    end
    ready_pct = 100;

    // Reset mid-job: outputs return to zero and no completion follows
    c0 = complete_cnt;
    @(posedge clk);
    #1;
    opcode = '0;
    opcode[15:0]  = 16'd20;
    opcode[19:16] = 4'd8;
    opcode_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    opcode_valid = 1'b0;
    datain_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    datain_valid = 1'b0;
    exp_q = {};
    @(negedge clk);
    check("midrst_accept", DW'(opcode_accept), DW'(0));
    check("midrst_complete", DW'(opcode_complete), DW'(0));
    check("midrst_datain_ready", DW'(datain_ready), DW'(0));
    check("midrst_dataout_valid", DW'(dataout_valid), DW'(0));
    check("midrst_dataout", dataout, '0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    check("midrst_no_complete", DW'(complete_cnt), DW'(c0));
    check("midrst_idle_ready", DW'(datain_ready), DW'(0));

    // Pipeline still usable after the abort
    run_job(7, 2, 0, 100, -1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
